// File: rtl/ex_div.sv
// Iterative RV32M divide/remainder for the execute stage: restoring division,
// one quotient bit per cycle, result written straight to the register file.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_wen_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rem, r_quot, r_dvsr;
    logic              r_qneg, r_rneg;
    logic [4:0]        r_waddr;
    logic [XLEN-1:0]   r_wdata;

    logic              w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [XLEN:0]     w_rem_sh, w_diff;
    logic              w_ge, w_last;
    logic [XLEN-1:0]   w_rem_nx, w_quot_nx, w_q_fin, w_r_fin, w_result;

    // op_i[0]=0 selects the signed variants (DIV, REM)
    assign w_signed = ~op_i[0];
    assign w_a_neg  = w_signed & dividend_i[XLEN-1];
    assign w_b_neg  = w_signed & divisor_i[XLEN-1];
    assign w_a_mag  = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag  = w_b_neg ? -divisor_i : divisor_i;

    assign w_div0    = (divisor_i == '0);
    assign w_ovf     = w_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
    assign w_special = w_div0 | w_ovf;
    // Overflow DIV returns the dividend itself (0x80000000), overflow REM returns 0
    assign w_special_res = w_div0 ? (op_i[1] ? dividend_i : '1)
                                  : (op_i[1] ? '0 : dividend_i);

    // Shifted partial remainder is always < 2*divisor, so bit XLEN of the
    // 33-bit difference is a valid borrow/sign indicator.
    assign w_rem_sh  = {r_rem, r_quot[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quot_nx = {r_quot[XLEN-2:0], w_ge};
    assign w_q_fin   = r_qneg ? -w_quot_nx : w_quot_nx;
    assign w_r_fin   = r_rneg ? -w_rem_nx : w_rem_nx;
    assign w_result  = r_op[1] ? w_r_fin : w_q_fin;
    assign w_last    = (r_cnt == CNT_W'(XLEN-1));

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start_i) w_next = w_special ? S_DONE : S_CALC;
                S_CALC:  if (w_last) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_dvsr  <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (flush_i) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (start_i) begin
                        r_op   <= op_i;
                        r_rd   <= rd_addr_i;
                        r_rem  <= '0;
                        r_quot <= w_a_mag;
                        r_dvsr <= w_b_mag;
                        r_qneg <= w_a_neg ^ w_b_neg;
                        r_rneg <= w_a_neg;
                        r_cnt  <= '0;
                        if (w_special) begin
                            r_waddr <= rd_addr_i;
                            r_wdata <= w_special_res;
                        end
                    end
                    S_CALC: begin
                        r_rem  <= w_rem_nx;
                        r_quot <= w_quot_nx;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_waddr <= r_rd;
                            r_wdata <= w_result;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    // x0 writes and flushed results never reach the register file
    assign reg_wen_o   = (r_state == S_DONE) && (r_rd != 5'd0) && !flush_i;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;

endmodule
